// File: rtl/transpose_tile_ctrl.sv
// rtl/transpose_tile_ctrl.sv - single-bank SRAM sequencer that transposes a DIM x DIM tile
// Fills the bank row-major from the input stream, then drains it column-major through a 2-entry buffer.
module transpose_tile_ctrl #(
  parameter int DIM       = 8,
  parameter int Data_W    = 16,
  parameter int ADDR_W    = 12,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [Data_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [Data_W-1:0] out_data,
  output logic              out_last,
  output logic              busy,
  output logic              sram_cs,
  output logic              sram_we,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [Data_W-1:0] sram_wdata,
  input  logic [Data_W-1:0] sram_rdata
);

  localparam int CW = (DIM > 1) ? $clog2(DIM) : 1;
  localparam logic [CW-1:0]     LAST   = CW'(DIM - 1);
  localparam logic [ADDR_W-1:0] DIM_A  = ADDR_W'(DIM);
  localparam logic [ADDR_W-1:0] BASE_A = ADDR_W'(BASE_ADDR);

  typedef enum logic [1:0] {IDLE, FILL, DRAIN} state_t;
  state_t state, state_nxt;

  logic [CW-1:0]     r, c;
  logic              rd_done, inflight, inflight_last;
  logic [Data_W-1:0] buf_data [2];
  logic [1:0]        buf_last;
  logic              rd_ptr, wr_ptr;
  logic [1:0]        count;
  logic [2:0]        occ;
  logic              in_hs, out_hs, issue, at_last;
  logic [ADDR_W-1:0] tile_addr;

  assign in_ready  = (state != DRAIN);
  assign busy      = (state != IDLE);
  assign in_hs     = in_valid & in_ready;
  assign out_valid = (count != 2'd0);
  assign out_data  = buf_data[rd_ptr];
  assign out_last  = out_valid & buf_last[rd_ptr];
  assign out_hs    = out_valid & out_ready;
  assign at_last   = (r == LAST) && (c == LAST);
  assign tile_addr = BASE_A + ADDR_W'(r) * DIM_A + ADDR_W'(c);

  // A pop in the same cycle frees its slot, which keeps the drain at one element per cycle.
  assign occ   = 3'(count) + 3'(inflight) - 3'(out_hs);
  assign issue = (state == DRAIN) && !rd_done && (occ < 3'd2);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_hs) state_nxt = FILL;
      FILL:    if (in_hs && at_last) state_nxt = DRAIN;
      DRAIN:   if (out_hs && out_last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    sram_cs    = 1'b0;
    sram_we    = 1'b0;
    sram_addr  = '0;
    sram_wdata = '0;
    if (in_hs) begin
      sram_cs    = 1'b1;
      sram_we    = 1'b1;
      sram_addr  = tile_addr;
      sram_wdata = in_data;
    end else if (issue) begin
      sram_cs   = 1'b1;
      sram_addr = tile_addr;
    end
  end

  // Both walks end on (LAST, LAST) and wrap back to (0, 0), ready for the next phase.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r <= '0;
      c <= '0;
    end else if (in_hs) begin
      if (c == LAST) begin
        c <= '0;
        r <= (r == LAST) ? '0 : r + CW'(1);
      end else begin
        c <= c + CW'(1);
      end
    end else if (issue) begin
      if (r == LAST) begin
        r <= '0;
        c <= (c == LAST) ? '0 : c + CW'(1);
      end else begin
        r <= r + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_done       <= 1'b0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
    end else begin
      inflight      <= issue;
      inflight_last <= issue && at_last;
      if (state != DRAIN)        rd_done <= 1'b0;
      else if (issue && at_last) rd_done <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_data[0] <= '0;
      buf_data[1] <= '0;
      buf_last    <= '0;
      rd_ptr      <= 1'b0;
      wr_ptr      <= 1'b0;
      count       <= 2'd0;
    end else begin
      if (inflight) begin
        buf_data[wr_ptr] <= sram_rdata;
        buf_last[wr_ptr] <= inflight_last;
        wr_ptr           <= ~wr_ptr;
      end
      if (out_hs) rd_ptr <= ~rd_ptr;
      case ({inflight, out_hs})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule
